iir_coeff_loader: RTL and testbench
===================================

# iir_coeff_loader

Coefficient configuration controller for the three-stage notch IIR chain (2.4 MHz -> 1 MHz -> 2 MHz). It accepts framed coefficient writes on a valid/ready stream and assembles five coefficients per frame in a shadow buffer. It then commits them atomically to the selected notch stage with a one-cycle write-enable pulse, issued only between input samples. It also reports completion and frame errors to the configuring master.

## Interface
Parameters:
- COEFF_WIDTH, 20, coefficient word width (signed, Q2.18 in current chain)
- COEFF_DEPTH, 5, coefficients per filter (3 numerator + 2 denominator); fixed, not overridable
- TIMEOUT_CYCLES, 1024, max idle cycles between beats inside a frame

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  beat valid
- cfg_ready  out  1  beat accepted when cfg_valid && cfg_ready
- cfg_sel  in  2  target stage: 0 = 1 MHz, 1 = 2 MHz, 2 = 2.4 MHz, 3 = illegal; sampled on first beat only
- cfg_data  in  COEFF_WIDTH  coefficient word, index order b0, b1, b2, a1, a2
- cfg_last  in  1  marks final beat of frame
- chain_valid_in  in  1  sample valid entering the chain (same signal driving the first stage's valid_in)
- coeff_wr_en_1MHz / _2MHz / _2_4MHz  out  1 each  one-cycle commit pulse to the corresponding stage
- coeff_in_1MHz / _2MHz / _2_4MHz  out  COEFF_WIDTH x COEFF_DEPTH each  registered coefficient arrays to each stage
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse, coincident with the commit pulse
- err  out  1  one-cycle pulse on frame error
- err_code  out  2  01 = bad sel, 10 = length, 11 = timeout; 00 = none

## Operation
- States: IDLE, COLLECT, DRAIN, WAIT_GAP, COMMIT.
- IDLE: cfg_ready = 1.
  - On an accepted beat: latch cfg_sel into sel_q, clear err_code, and store cfg_data at shadow[0]. Set cnt = 1.
  - If cfg_sel == 3: go to DRAIN with pending code 01. If cfg_last is also set on that beat, skip DRAIN and pulse err/01 next cycle.
  - If cfg_last is set on a legal first beat: length error (err pulse, code 10), stay in IDLE.
  - Otherwise go to COLLECT.
- COLLECT: cfg_ready = 1. Each accepted beat writes shadow[cnt] and increments cnt.
  - cfg_last with cnt < 4: err/10, return to IDLE.
  - Beat at cnt == 4 with cfg_last: go to WAIT_GAP.
  - Beat at cnt == 4 without cfg_last: go to DRAIN with pending code 10.
  - cfg_sel on non-first beats is ignored.
- DRAIN: cfg_ready = 1. Accepted beats are discarded. On accepted cfg_last: pulse err with the pending code, go to IDLE.
- Timeout: a counter runs in COLLECT and DRAIN, reset on every accepted beat. When it reaches TIMEOUT_CYCLES with no beat, pulse err with code 11, go to IDLE, and discard the shadow.
- WAIT_GAP: cfg_ready = 0. Wait for a cycle with chain_valid_in == 0. In that cycle, load coeff_in_<sel_q> from the shadow and go to COMMIT.
- COMMIT: cfg_ready = 0. Assert coeff_wr_en_<sel_q> and done for exactly this cycle, then go to IDLE.
- Non-selected coeff_in arrays hold their previous committed values. The stages keep their own coefficient registers, so the arrays only need to be valid while wr_en is high.
- Only one wr_en is ever high in any cycle.
- No arithmetic on coefficients; words are passed bit-exact.

## Timing
- Reset values: cfg_ready = 0 during reset, 1 in the first cycle after reset is released. All wr_en = 0, all coeff_in arrays = 0, busy = 0, done = 0, err = 0, err_code = 00, state = IDLE, cnt = 0, timeout counter = 0.
- Latency: last beat accepted in cycle t -> WAIT_GAP in t+1.
  - If chain_valid_in = 0 in t+1: wr_en and done are high in t+2.
  - Each cycle with chain_valid_in high stalls the commit by one cycle.
- Back-to-back frames:
  - cfg_ready returns to 1 in the cycle after COMMIT.
  - Minimum frame-to-frame period is 7 cycles (5 beats + WAIT_GAP + COMMIT).
- err pulses the cycle after the offending beat or the timeout expiry. err_code holds until the next frame's first accepted beat.
- Reset mid-frame or in WAIT_GAP aborts with no wr_en pulse. Coefficients held inside the stages are untouched.
- If chain_valid_in is continuously high, the block stays in WAIT_GAP indefinitely. This is legal; the chain decimates, so gaps are guaranteed.

## Test plan
- Nominal: sel = 2, words 0x00100, 0x3FF00, 0x00100, 0x3FE80, 0x00F00 with chain_valid_in = 0 -> coeff_wr_en_2_4MHz high exactly 2 cycles after the last beat. coeff_in_2_4MHz matches bit-exact. done coincident. Other arrays stay 0.
- Gap wait: same frame to sel = 0 with chain_valid_in held high for 6 cycles after the last beat -> cfg_ready = 0 throughout; coeff_wr_en_1MHz pulses in the cycle after the first low cycle.
- Errors:
  - sel = 3 frame of 5 beats -> no wr_en; err/01 the cycle after beat 5.
  - 3-beat frame -> err/10.
  - 7-beat frame -> err/10 after beat 7.
- Timeout: 2 beats then cfg_valid = 0 for 1024 cycles -> err/11. The next valid 5-beat frame to sel = 1 commits normally.
- Reset in WAIT_GAP: assert rst for 1 cycle -> no wr_en, all outputs at reset values, cfg_ready = 1 in the cycle after rst falls.
- Back-to-back frames to sel = 0, 1, 2 with backpressure-free master -> three single wr_en pulses on distinct stages, 7 cycles apart.

Source files
------------

// File: rtl/iir_coeff_loader_if.sv
// iir_coeff_loader_if: config stream, chain sample strobe and per-stage coefficient bus
// Ports (slave view): cfg_valid/cfg_ready/cfg_sel/cfg_data/cfg_last config beats in,
// chain_valid_in sample strobe in, coeff_wr_en_*/coeff_in_* per-stage commit out,
// busy/done/err/err_code status out. The master modport is the mirror image.
interface iir_coeff_loader_if #(parameter int COEFF_WIDTH = 20);
    localparam int COEFF_DEPTH = 5;
    logic                                    cfg_valid;
    logic                                    cfg_ready;
    logic [1:0]                              cfg_sel;
    logic [COEFF_WIDTH-1:0]                  cfg_data;
    logic                                    cfg_last;
    logic                                    chain_valid_in;
    logic                                    coeff_wr_en_1MHz;
    logic                                    coeff_wr_en_2MHz;
    logic                                    coeff_wr_en_2_4MHz;
    logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_in_1MHz;
    logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_in_2MHz;
    logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] coeff_in_2_4MHz;
    logic                                    busy;
    logic                                    done;
    logic                                    err;
    logic [1:0]                              err_code;
    modport master (
        output cfg_valid, cfg_sel, cfg_data, cfg_last, chain_valid_in,
        input  cfg_ready, coeff_wr_en_1MHz, coeff_wr_en_2MHz, coeff_wr_en_2_4MHz,
        input  coeff_in_1MHz, coeff_in_2MHz, coeff_in_2_4MHz, busy, done, err, err_code
    );
    modport slave (
        input  cfg_valid, cfg_sel, cfg_data, cfg_last, chain_valid_in,
        output cfg_ready, coeff_wr_en_1MHz, coeff_wr_en_2MHz, coeff_wr_en_2_4MHz,
        output coeff_in_1MHz, coeff_in_2MHz, coeff_in_2_4MHz, busy, done, err, err_code
    );
endinterface

// File: rtl/iir_coeff_loader.sv
// iir_coeff_loader: collects 5-word coefficient frames and commits them atomically to one notch stage
// Ports: clk, rst (sync, active-high); bus (slave modport) carries the config stream,
// the chain sample strobe, per-stage coefficient arrays with commit pulses, and status.
module iir_coeff_loader #(
    parameter int COEFF_WIDTH    = 20,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    iir_coeff_loader_if.slave bus
);
    localparam int COEFF_DEPTH = 5;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    typedef logic [COEFF_DEPTH-1:0][COEFF_WIDTH-1:0] arr_t;
    typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, WAIT_GAP, COMMIT} state_t;
    state_t state_q, state_d;
    logic [1:0] sel_q, sel_d, pend_q, pend_d, code_q, code_d;
    logic [2:0] cnt_q, cnt_d;
    logic [TW-1:0] to_q, to_d;
    logic err_q, err_d;
    arr_t shadow_q, shadow_d, c1_q, c1_d, c2_q, c2_d, c24_q, c24_d;
    logic ready, acc, tmo;
    // Held low through reset so the master never sees a beat accepted while the block is cleared.
    assign ready = !rst && (state_q == IDLE || state_q == COLLECT || state_q == DRAIN);
    assign acc   = bus.cfg_valid && ready;
    assign tmo   = (state_q == COLLECT || state_q == DRAIN) && !acc && to_q == TO_LAST;
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        pend_d   = pend_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        shadow_d = shadow_q;
        c1_d     = c1_q;
        c2_d     = c2_q;
        c24_d    = c24_q;
        to_d     = (state_q == COLLECT || state_q == DRAIN) && !acc ? to_q + 1'b1 : '0;
        case (state_q)
            IDLE: if (acc) begin
                sel_d       = bus.cfg_sel;
                code_d      = 2'b00;
                shadow_d[0] = bus.cfg_data;
                cnt_d       = 3'd1;
                if (bus.cfg_sel == 2'd3) begin
                    if (bus.cfg_last) begin
                        err_d  = 1'b1;
                        code_d = 2'b01;
                    end else begin
                        state_d = DRAIN;
                        pend_d  = 2'b01;
                    end
                end else if (bus.cfg_last) begin
                    err_d  = 1'b1;
                    code_d = 2'b10;
                end else begin
                    state_d = COLLECT;
                end
            end
            COLLECT: if (acc) begin
                shadow_d[cnt_q] = bus.cfg_data;
                cnt_d           = cnt_q + 3'd1;
                if (cnt_q == 3'd4) begin
                    state_d = bus.cfg_last ? WAIT_GAP : DRAIN;
                    pend_d  = 2'b10;
                end else if (bus.cfg_last) begin
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                    state_d = IDLE;
                end
            end
            DRAIN: if (acc && bus.cfg_last) begin
                err_d   = 1'b1;
                code_d  = pend_q;
                state_d = IDLE;
            end
            // Load only in a cycle with no sample entering the chain so a stage never
            // filters one sample with a mix of old and new coefficients.
            WAIT_GAP: if (!bus.chain_valid_in) begin
                c1_d    = sel_q == 2'd0 ? shadow_q : c1_q;
                c2_d    = sel_q == 2'd1 ? shadow_q : c2_q;
                c24_d   = sel_q == 2'd2 ? shadow_q : c24_q;
                state_d = COMMIT;
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tmo) begin
            state_d = IDLE;
            err_d   = 1'b1;
            code_d  = 2'b11;
            to_d    = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            pend_q   <= '0;
            code_q   <= '0;
            cnt_q    <= '0;
            to_q     <= '0;
            err_q    <= 1'b0;
            shadow_q <= '0;
            c1_q     <= '0;
            c2_q     <= '0;
            c24_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            pend_q   <= pend_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
            c24_q    <= c24_d;
        end
    end
    assign bus.cfg_ready          = ready;
    assign bus.coeff_wr_en_1MHz   = state_q == COMMIT && sel_q == 2'd0;
    assign bus.coeff_wr_en_2MHz   = state_q == COMMIT && sel_q == 2'd1;
    assign bus.coeff_wr_en_2_4MHz = state_q == COMMIT && sel_q == 2'd2;
    assign bus.coeff_in_1MHz      = c1_q;
    assign bus.coeff_in_2MHz      = c2_q;
    assign bus.coeff_in_2_4MHz    = c24_q;
    assign bus.busy               = state_q != IDLE;
    assign bus.done               = state_q == COMMIT;
    assign bus.err                = err_q;
    assign bus.err_code           = code_q;
endmodule

// File: tb/tb_iir_coeff_loader.sv
// tb_iir_coeff_loader: directed self-checking bench for iir_coeff_loader
module tb_iir_coeff_loader;
    localparam int W = 20;
    typedef logic [4:0][W-1:0] arr_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [W-1:0] words [5] = '{20'h00100, 20'h3FF00, 20'h00100, 20'h3FE80, 20'h00F00};
    logic [2:0] wr;
    iir_coeff_loader_if #(.COEFF_WIDTH(W)) bus();
    iir_coeff_loader #(.COEFF_WIDTH(W), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    assign wr = {bus.coeff_wr_en_2_4MHz, bus.coeff_wr_en_2MHz, bus.coeff_wr_en_1MHz};

    function automatic arr_t frame_exp(input logic [W-1:0] key);
        arr_t a;
        for (int i = 0; i < 5; i++) a[i] = words[i] ^ key;
        return a;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic send_beats(input logic [1:0] sel, input int start, input int n,
                              input logic last_final, input logic [W-1:0] key);
        for (int i = start; i < start + n; i++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_sel   = sel;
            bus.cfg_data  = words[i % 5] ^ key;
            bus.cfg_last  = last_final && (i == start + n - 1);
            tests++;
            if (bus.cfg_ready !== 1'b1) begin
                fails++;
                $display("FAIL beat_ready beat %0d got %b exp 1", i, bus.cfg_ready);
            end
            tick;
        end
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        tests++;
        if (bus.cfg_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b exp 0", bus.cfg_ready); end
        tests++;
        if ({wr, bus.busy, bus.done, bus.err, bus.err_code} !== 8'h00) begin
            fails++;
            $display("FAIL rst_status got wr=%b busy=%b done=%b err=%b code=%b exp all 0",
                     wr, bus.busy, bus.done, bus.err, bus.err_code);
        end
        tests++;
        if ({bus.coeff_in_1MHz, bus.coeff_in_2MHz, bus.coeff_in_2_4MHz} !== '0) begin
            fails++;
            $display("FAIL rst_coeffs got nonzero exp 0");
        end
        rst = 1'b0;
        #1;
        tests++;
        if (bus.cfg_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b exp 1", bus.cfg_ready); end
    endtask

    task automatic test_nominal;
        send_beats(2'd2, 0, 5, 1'b1, '0);
        tests++;
        if ({bus.cfg_ready, bus.busy, wr} !== 5'b01000) begin
            fails++;
            $display("FAIL nom_wait_gap got ready=%b busy=%b wr=%b exp 0 1 000", bus.cfg_ready, bus.busy, wr);
        end
        tick;
        tests++;
        if ({wr, bus.done} !== 4'b1001) begin
            fails++;
            $display("FAIL nom_commit got wr=%b done=%b exp 100 1", wr, bus.done);
        end
        tests++;
        if (bus.coeff_in_2_4MHz !== frame_exp('0)) begin
            fails++;
            $display("FAIL nom_coeff got %h exp %h", bus.coeff_in_2_4MHz, frame_exp('0));
        end
        tests++;
        if ({bus.coeff_in_1MHz, bus.coeff_in_2MHz} !== '0) begin
            fails++;
            $display("FAIL nom_other_arrays got %h %h exp 0", bus.coeff_in_1MHz, bus.coeff_in_2MHz);
        end
        tick;
        tests++;
        if ({wr, bus.done, bus.cfg_ready, bus.busy} !== 6'b000010) begin
            fails++;
            $display("FAIL nom_after got wr=%b done=%b ready=%b busy=%b exp 000 0 1 0",
                     wr, bus.done, bus.cfg_ready, bus.busy);
        end
    endtask

    task automatic test_gap_wait;
        bus.chain_valid_in = 1'b1;
        send_beats(2'd0, 0, 5, 1'b1, 20'h0A5A5);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if ({bus.cfg_ready, wr} !== 4'b0000) begin
                fails++;
                $display("FAIL gap_stall cycle %0d got ready=%b wr=%b exp 0 000", i, bus.cfg_ready, wr);
            end
            tick;
        end
        bus.chain_valid_in = 1'b0;
        tests++;
        if (wr !== 3'b000) begin fails++; $display("FAIL gap_low_cycle got wr=%b exp 000", wr); end
        tick;
        tests++;
        if ({wr, bus.done} !== 4'b0011) begin
            fails++;
            $display("FAIL gap_commit got wr=%b done=%b exp 001 1", wr, bus.done);
        end
        tests++;
        if (bus.coeff_in_1MHz !== frame_exp(20'h0A5A5)) begin
            fails++;
            $display("FAIL gap_coeff got %h exp %h", bus.coeff_in_1MHz, frame_exp(20'h0A5A5));
        end
        tests++;
        if (bus.coeff_in_2_4MHz !== frame_exp('0)) begin
            fails++;
            $display("FAIL gap_hold_other got %h exp %h", bus.coeff_in_2_4MHz, frame_exp('0));
        end
        tick;
    endtask

    task automatic test_errors;
        send_beats(2'd3, 0, 5, 1'b1, '0);
        tests++;
        if ({bus.err, bus.err_code, wr} !== 6'b101000) begin
            fails++;
            $display("FAIL err_badsel got err=%b code=%b wr=%b exp 1 01 000", bus.err, bus.err_code, wr);
        end
        tick;
        tests++;
        if ({bus.err, bus.err_code, wr} !== 6'b001000) begin
            fails++;
            $display("FAIL err_code_hold got err=%b code=%b wr=%b exp 0 01 000", bus.err, bus.err_code, wr);
        end
        send_beats(2'd0, 0, 3, 1'b1, '0);
        tests++;
        if ({bus.err, bus.err_code, bus.busy} !== 4'b1100) begin
            fails++;
            $display("FAIL err_short got err=%b code=%b busy=%b exp 1 10 0", bus.err, bus.err_code, bus.busy);
        end
        tick;
        send_beats(2'd1, 0, 1, 1'b0, '0);
        tests++;
        if ({bus.err_code, bus.busy} !== 3'b001) begin
            fails++;
            $display("FAIL err_code_clear got code=%b busy=%b exp 00 1", bus.err_code, bus.busy);
        end
        send_beats(2'd1, 1, 4, 1'b0, '0);
        tests++;
        if ({bus.err, bus.busy} !== 2'b01) begin
            fails++;
            $display("FAIL err_long_mid got err=%b busy=%b exp 0 1", bus.err, bus.busy);
        end
        send_beats(2'd1, 5, 2, 1'b1, '0);
        tests++;
        if ({bus.err, bus.err_code, wr} !== 6'b110000) begin
            fails++;
            $display("FAIL err_long got err=%b code=%b wr=%b exp 1 10 000", bus.err, bus.err_code, wr);
        end
        tick;
        tests++;
        if (bus.coeff_in_2MHz !== '0) begin
            fails++;
            $display("FAIL err_no_commit got %h exp 0", bus.coeff_in_2MHz);
        end
    endtask

    task automatic test_timeout;
        int n;
        send_beats(2'd0, 0, 2, 1'b0, '0);
        n = 0;
        while (bus.err !== 1'b1 && n < 1100) begin
            tick;
            n++;
        end
        tests++;
        if (n != 1024) begin fails++; $display("FAIL tmo_latency got %0d exp 1024", n); end
        tests++;
        if ({bus.err_code, bus.busy, wr} !== 6'b110000) begin
            fails++;
            $display("FAIL tmo_code got code=%b busy=%b wr=%b exp 11 0 000", bus.err_code, bus.busy, wr);
        end
        send_beats(2'd1, 0, 5, 1'b1, 20'h13579);
        tick;
        tests++;
        if ({wr, bus.done} !== 4'b0101) begin
            fails++;
            $display("FAIL tmo_next_commit got wr=%b done=%b exp 010 1", wr, bus.done);
        end
        tests++;
        if (bus.coeff_in_2MHz !== frame_exp(20'h13579)) begin
            fails++;
            $display("FAIL tmo_next_coeff got %h exp %h", bus.coeff_in_2MHz, frame_exp(20'h13579));
        end
        tick;
    endtask

    task automatic test_reset_wait_gap;
        bus.chain_valid_in = 1'b1;
        send_beats(2'd2, 0, 5, 1'b1, 20'h0FFFF);
        tests++;
        if (bus.busy !== 1'b1) begin fails++; $display("FAIL rwg_busy got %b exp 1", bus.busy); end
        rst = 1'b1;
        tick;
        tests++;
        if ({bus.cfg_ready, bus.busy, bus.done, bus.err, bus.err_code, wr} !== 9'h000) begin
            fails++;
            $display("FAIL rwg_outputs got ready=%b busy=%b done=%b err=%b code=%b wr=%b exp all 0",
                     bus.cfg_ready, bus.busy, bus.done, bus.err, bus.err_code, wr);
        end
        tests++;
        if ({bus.coeff_in_1MHz, bus.coeff_in_2MHz, bus.coeff_in_2_4MHz} !== '0) begin
            fails++;
            $display("FAIL rwg_coeffs got nonzero exp 0");
        end
        rst = 1'b0;
        bus.chain_valid_in = 1'b0;
        #1;
        tests++;
        if (bus.cfg_ready !== 1'b1) begin fails++; $display("FAIL rwg_ready got %b exp 1", bus.cfg_ready); end
        for (int i = 0; i < 4; i++) begin
            tick;
            tests++;
            if ({wr, bus.done} !== 4'b0000) begin
                fails++;
                $display("FAIL rwg_no_commit cycle %0d got wr=%b done=%b exp 000 0", i, wr, bus.done);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] keys [3] = '{20'h11111, 20'h22222, 20'h33333};
        int f = 0;
        int b = 0;
        int np = 0;
        int pc [3] = '{-1, -1, -1};
        logic [2:0] pw [3] = '{3'b000, 3'b000, 3'b000};
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (wr !== 3'b000) begin
                if (np < 3) begin
                    pc[np] = cyc;
                    pw[np] = wr;
                end
                np++;
            end
            if (f < 3 && bus.cfg_ready === 1'b1) begin
                bus.cfg_valid = 1'b1;
                bus.cfg_sel   = 2'(f);
                bus.cfg_data  = words[b] ^ keys[f];
                bus.cfg_last  = (b == 4);
                b++;
                if (b == 5) begin
                    b = 0;
                    f++;
                end
            end else begin
                bus.cfg_valid = 1'b0;
                bus.cfg_last  = 1'b0;
            end
            tick;
        end
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
        tests++;
        if (np != 3) begin fails++; $display("FAIL b2b_pulse_count got %0d exp 3", np); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (pc[i] != 6 + 7 * i || pw[i] !== 3'(1 << i)) begin
                fails++;
                $display("FAIL b2b_pulse %0d got cycle=%0d wr=%b exp cycle=%0d wr=%b",
                         i, pc[i], pw[i], 6 + 7 * i, 3'(1 << i));
            end
        end
        tests++;
        if ({bus.coeff_in_1MHz, bus.coeff_in_2MHz, bus.coeff_in_2_4MHz} !==
            {frame_exp(keys[0]), frame_exp(keys[1]), frame_exp(keys[2])}) begin
            fails++;
            $display("FAIL b2b_coeffs got %h %h %h", bus.coeff_in_1MHz, bus.coeff_in_2MHz, bus.coeff_in_2_4MHz);
        end
    endtask

    initial begin
        bus.cfg_valid      = 1'b0;
        bus.cfg_sel        = 2'd0;
        bus.cfg_data       = '0;
        bus.cfg_last       = 1'b0;
        bus.chain_valid_in = 1'b0;
        test_reset;
        test_nominal;
        test_gap_wait;
        test_errors;
        test_timeout;
        test_reset_wait_gap;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
